// File: rtl/fetch_pc_gen.sv
// Program-counter generator with fetch lock: advances PC sequentially and freezes
// fetch on each control-flow instruction until the branch unit resolves its target.
module fetch_pc_gen #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pc_stall,
  input  logic                 fetch_valid,
  input  logic                 fetch_is_ctrl,
  input  logic                 bra_resolve_valid,
  input  logic                 bra_resolve_taken,
  input  logic [PC_WIDTH-1:0]  bra_resolve_target,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 pc_valid,
  output logic                 pc_locked,
  output logic [CNT_WIDTH-1:0] lock_cycles
);

  // state  | meaning
  // IDLE   | just out of reset, pc not yet live
  // RUN    | sequential fetch, pc advances on each unstalled fetch
  // LOCKED | control-flow instruction fetched, waiting for resolution
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    LOCKED = 2'b10
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  state_t                state;
  state_t                state_next;
  logic [PC_WIDTH-1:0]   fallthrough;
  logic [PC_WIDTH-1:0]   fallthrough_next;
  logic [PC_WIDTH-1:0]   pc_next;
  logic [CNT_WIDTH-1:0]  lock_cycles_next;
  logic                  lock_entry;

  assign lock_entry = !pc_stall && fetch_valid && fetch_is_ctrl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = RUN;
      RUN:     if (lock_entry) state_next = LOCKED;
      LOCKED:  if (bra_resolve_valid) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pc_next          = pc;
    fallthrough_next = fallthrough;
    lock_cycles_next = lock_cycles;
    case (state)
      RUN: begin
        if (lock_entry) begin
          fallthrough_next = pc + PC_STEP;
        end else if (!pc_stall && fetch_valid) begin
          pc_next = pc + PC_STEP;
        end
      end
      LOCKED: begin
        if (lock_cycles != {CNT_WIDTH{1'b1}}) begin
          lock_cycles_next = lock_cycles + CNT_WIDTH'(1);
        end
        if (bra_resolve_valid) begin
          pc_next = bra_resolve_taken ? {bra_resolve_target[PC_WIDTH-1:2], 2'b00} : fallthrough;
        end
      end
      default: ;
    endcase
  end

  // Flags are derived from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      pc_valid    <= 1'b0;
      pc_locked   <= 1'b0;
      lock_cycles <= '0;
      fallthrough <= '0;
    end else begin
      pc          <= pc_next;
      pc_valid    <= (state_next == RUN);
      pc_locked   <= (state_next == LOCKED);
      lock_cycles <= lock_cycles_next;
      fallthrough <= fallthrough_next;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: two instances (default, and wrap/saturation parameters)
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_stall = 1'b0;
  logic        fetch_valid = 1'b0;
  logic        fetch_is_ctrl = 1'b0;
  logic        bra_resolve_valid = 1'b0;
  logic        bra_resolve_taken = 1'b0;
  logic [31:0] bra_resolve_target = '0;

  logic [31:0] pc_a, pc_b;
  logic        valid_a, valid_b, locked_a, locked_b;
  logic [15:0] lc_a;
  logic [3:0]  lc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_pc_gen #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .pc_stall(pc_stall), .fetch_valid(fetch_valid),
    .fetch_is_ctrl(fetch_is_ctrl), .bra_resolve_valid(bra_resolve_valid),
    .bra_resolve_taken(bra_resolve_taken), .bra_resolve_target(bra_resolve_target),
    .pc(pc_a), .pc_valid(valid_a), .pc_locked(locked_a), .lock_cycles(lc_a)
  );

  fetch_pc_gen #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .pc_stall(pc_stall), .fetch_valid(fetch_valid),
    .fetch_is_ctrl(fetch_is_ctrl), .bra_resolve_valid(bra_resolve_valid),
    .bra_resolve_taken(bra_resolve_taken), .bra_resolve_target(bra_resolve_target),
    .pc(pc_b), .pc_valid(valid_b), .pc_locked(locked_b), .lock_cycles(lc_b)
  );

  // Behavioural model: "started" and "locked" flags, two PCs, two counters.
  logic        m_started, m_locked;
  logic [31:0] m_pc_a, m_pc_b, m_ft_a, m_ft_b;
  int          m_cnt_a, m_cnt_b;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_started <= 1'b0;
      m_locked  <= 1'b0;
      m_pc_a    <= 32'h0000_0000;
      m_pc_b    <= 32'hFFFF_FFF8;
      m_ft_a    <= '0;
      m_ft_b    <= '0;
      m_cnt_a   <= 0;
      m_cnt_b   <= 0;
    end else if (!m_started) begin
      m_started <= 1'b1;
    end else if (m_locked) begin
      m_cnt_a <= (m_cnt_a < 65535) ? m_cnt_a + 1 : m_cnt_a;
      m_cnt_b <= (m_cnt_b < 15) ? m_cnt_b + 1 : m_cnt_b;
      if (bra_resolve_valid) begin
        m_locked <= 1'b0;
        m_pc_a   <= bra_resolve_taken ? (bra_resolve_target & ~32'h3) : m_ft_a;
        m_pc_b   <= bra_resolve_taken ? (bra_resolve_target & ~32'h3) : m_ft_b;
      end
    end else if (!pc_stall && fetch_valid) begin
      if (fetch_is_ctrl) begin
        m_locked <= 1'b1;
        m_ft_a   <= m_pc_a + 32'd4;
        m_ft_b   <= m_pc_b + 32'd4;
      end else begin
        m_pc_a <= m_pc_a + 32'd4;
        m_pc_b <= m_pc_b + 32'd4;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("model_pc_a",     pc_a,             m_pc_a);
    check("model_pc_b",     pc_b,             m_pc_b);
    check("model_valid_a",  {31'b0, valid_a}, {31'b0, m_started && !m_locked});
    check("model_valid_b",  {31'b0, valid_b}, {31'b0, m_started && !m_locked});
    check("model_locked_a", {31'b0, locked_a}, {31'b0, m_locked});
    check("model_locked_b", {31'b0, locked_b}, {31'b0, m_locked});
    check("model_lc_a",     {16'b0, lc_a},    32'(m_cnt_a));
    check("model_lc_b",     {28'b0, lc_b},    32'(m_cnt_b));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    compare_all();
    check("reset_pc_a", pc_a, 32'h0);
    check("reset_pc_b", pc_b, 32'hFFFF_FFF8);
    check("reset_valid", {31'b0, valid_a}, 32'd0);

    rst = 1'b1; fetch_valid = 1'b1;
    tick();
    check("run_entry_pc", pc_a, 32'h0);
    check("run_entry_valid", {31'b0, valid_a}, 32'd1);
    tick();
    check("seq_pc_4", pc_a, 32'h4);
    check("seq_pc_b_fffc", pc_b, 32'hFFFF_FFFC);
    tick();
    check("seq_pc_8", pc_a, 32'h8);
    check("wrap_pc_b_0", pc_b, 32'h0);
    tick();
    check("seq_pc_c", pc_a, 32'hC);
    tick();
    check("seq_pc_10", pc_a, 32'h10);
    check("seq_unlocked", {31'b0, locked_a}, 32'd0);

    fetch_is_ctrl = 1'b1;
    tick();
    check("lock_pc", pc_a, 32'h10);
    check("lock_flag", {31'b0, locked_a}, 32'd1);
    check("lock_valid", {31'b0, valid_a}, 32'd0);
    repeat (4) tick();
    bra_resolve_valid = 1'b1; bra_resolve_taken = 1'b1; bra_resolve_target = 32'h103;
    tick();
    check("taken_pc", pc_a, 32'h100);
    check("taken_unlocked", {31'b0, locked_a}, 32'd0);
    check("taken_valid", {31'b0, valid_a}, 32'd1);
    check("taken_lc", {16'b0, lc_a}, 32'd5);

    // Strobe coincident with lock entry must be ignored.
    bra_resolve_target = 32'h555;
    tick();
    check("early_strobe_locked", {31'b0, locked_a}, 32'd1);
    check("early_strobe_pc", pc_a, 32'h100);
    bra_resolve_valid = 1'b0;
    tick();
    check("still_locked", {31'b0, locked_a}, 32'd1);
    bra_resolve_valid = 1'b1; bra_resolve_taken = 1'b0;
    tick();
    check("not_taken_pc", pc_a, 32'h104);
    check("not_taken_lc", {16'b0, lc_a}, 32'd7);

    bra_resolve_valid = 1'b0; pc_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc_a, 32'h104);
      check("stall_no_lock", {31'b0, locked_a}, 32'd0);
    end
    pc_stall = 1'b0;
    tick();
    check("unstall_lock", {31'b0, locked_a}, 32'd1);

    @(posedge clk);
    #2 rst = 1'b0;
    #1 compare_all();
    check("async_rst_pc", pc_a, 32'h0);
    check("async_rst_locked", {31'b0, locked_a}, 32'd0);
    check("async_rst_lc", {16'b0, lc_a}, 32'd0);
    check("async_rst_pc_b", pc_b, 32'hFFFF_FFF8);
    bra_resolve_valid = 1'b1; bra_resolve_taken = 1'b1; bra_resolve_target = 32'h200;
    fetch_valid = 1'b0; fetch_is_ctrl = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("late_strobe_idle_pc", pc_a, 32'h0);
    check("late_strobe_valid", {31'b0, valid_a}, 32'd1);
    tick();
    check("late_strobe_run_pc", pc_a, 32'h0);
    check("late_strobe_run_unlocked", {31'b0, locked_a}, 32'd0);
    bra_resolve_valid = 1'b0;

    fetch_valid = 1'b1; fetch_is_ctrl = 1'b1;
    tick();
    fetch_valid = 1'b0; fetch_is_ctrl = 1'b0;
    repeat (20) tick();
    check("sat_lc_b_hold", {28'b0, lc_b}, 32'd15);
    bra_resolve_valid = 1'b1; bra_resolve_taken = 1'b1; bra_resolve_target = 32'h40;
    tick();
    check("sat_lc_b", {28'b0, lc_b}, 32'd15);
    check("sat_lc_a", {16'b0, lc_a}, 32'd21);
    check("sat_pc", pc_a, 32'h40);
    bra_resolve_valid = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        #1 compare_all();
      end else begin
        rst = 1'b1;
      end
      pc_stall           = ($urandom_range(0, 3) == 0);
      fetch_valid        = ($urandom_range(0, 3) != 0);
      fetch_is_ctrl      = ($urandom_range(0, 5) == 0);
      bra_resolve_valid  = ($urandom_range(0, 4) == 0);
      bra_resolve_taken  = 1'($urandom_range(0, 1));
      bra_resolve_target = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
